// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared encodings for the EX-stage multiply/divide unit
package mult_div_unit_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// rtl/mult_div_unit_iter_core.sv - one-bit-per-cycle shift-add / restoring shift-subtract datapath
module mdu_iter_core
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   ma,
   input  logic [WIDTH-1:0]   mb,
   output logic [2*WIDTH-1:0] acc
);

   // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         opnd_q <= '0;
      end else if (load) begin
         acc_q  <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
         opnd_q <= is_div ? mb : ma;
      end else if (step) begin
         if (!is_div)
            acc_q <= {sum, acc_q[WIDTH-1:1]};
         else if (!diff[WIDTH])
            acc_q <= {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_q <= {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative mult/multu/div/divu unit with private HI/LO registers
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               div_q, neg_q, rneg_q, bzero_q, done_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               load, step, fin;
   logic               a_neg, b_neg, core_div;
   logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
   logic [2*WIDTH-1:0] acc, prod;

   assign a_neg    = !op[0] && a[WIDTH-1];
   assign b_neg    = !op[0] && b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;
   assign core_div = (state_q == S_IDLE) ? op[1] : div_q;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .is_div (core_div),
      .ma     (a_mag),
      .mb     (b_mag),
      .acc    (acc)
   );

   // Remainder follows the dividend sign, so divide-by-zero naturally returns the raw dividend in hi
   assign prod = neg_q  ? -acc : acc;
   assign quot = neg_q  ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               state_d = S_CALC;
               load    = 1'b1;
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               step = 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1))
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            fin     = !cancel;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         bzero_q <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= fin;
         if (load) begin
            cnt_q   <= '0;
            div_q   <= op[1];
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            bzero_q <= (b == '0);
         end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (fin) begin
            if (div_q) begin
               lo_q <= bzero_q ? '1 : quot;
               hi_q <= rem;
            end else begin
               {hi_q, lo_q} <= prod;
            end
         end else if (state_q == S_IDLE && !start) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
         end
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, wdata = '0;
   logic        hi_we = 1'b0, lo_we = 1'b0, cancel = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .cancel(cancel),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          issue;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%h required=0x%h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] r, ux, uy;
      longint      sx, sy, q, rm;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      r  = '0;
      if (o[1] && y == 32'd0) begin
         r = {x, 32'hFFFF_FFFF};
      end else begin
         case (o)
            MD_MULT:  r = sx * sy;
            MD_MULTU: r = ux * uy;
            MD_DIV: begin
               q  = sx / sy;
               rm = sx % sy;
               r  = {rm[31:0], q[31:0]};
            end
            default: begin
               r[31:0]  = 32'(ux / uy);
               r[63:32] = 32'(ux % uy);
            end
         endcase
      end
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit push, output int n);
      logic [63:0] m;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      n = cyc;
      if (push) begin
         m = model(o, x, y);
         sb.push_back('{hi: m[63:32], lo: m[31:0], issue: n});
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
      @(posedge clk); #1;
      hi_we = wh; lo_we = wl; wdata = d;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || sb.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_idle_timeout actual=busy%0d/pending%0d required=idle", busy, sb.size());
      end
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n;
      exp_t e;
      fork
         forever begin
            @(negedge clk);
            if (!reset && done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=hi 0x%h lo 0x%h required=no_done", hi, lo);
               end else begin
                  e = sb.pop_front();
                  check("result_hi", hi, e.hi);
                  check("result_lo", lo, e.lo);
                  check("latency", 32'(cyc - e.issue), 32'd34);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      // multu full-scale with busy window probing
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, n);
      @(negedge clk);
      check("busy_first", 32'(busy), 32'd1);
      while (cyc < n + 33) @(negedge clk);
      check("busy_last", 32'(busy), 32'd1);
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
      wait_idle();

      issue(MD_MULT, 32'hFFFF_FFF9, 32'd3, 1, n);           wait_idle();
      issue(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1, n);   wait_idle();
      issue(MD_DIV,  32'hFFFF_FFF9, 32'd2, 1, n);           wait_idle();
      issue(MD_DIVU, 32'd100, 32'd7, 1, n);                 wait_idle();
      issue(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, n);   wait_idle();
      issue(MD_DIVU, 32'h1234, 32'd0, 1, n);                wait_idle();
      issue(MD_DIV,  32'hFFFF_FF00, 32'd0, 1, n);           wait_idle();

      // mthi/mtlo and collisions
      mt(1, 1, 32'hA5A5_A5A5);
      @(negedge clk);
      check("mt_hi", hi, 32'hA5A5_A5A5);
      check("mt_lo", lo, 32'hA5A5_A5A5);
      issue(MD_DIVU, 32'd100, 32'd7, 1, n);
      repeat (3) @(posedge clk);
      #1 hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1 hi_we = 1'b0;
      @(negedge clk);
      check("mthi_while_busy", hi, 32'hA5A5_A5A5);
      wait_idle();
      @(posedge clk); #1;
      start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4; lo_we = 1'b1; wdata = 32'h5555_5555;
      sb.push_back('{hi: 32'd0, lo: 32'd12, issue: cyc});
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      @(negedge clk);
      check("mtlo_with_start", lo, 32'd14);
      wait_idle();

      // cancel in flight
      mt(1, 0, 32'h11);
      mt(0, 1, 32'h22);
      issue(MD_MULT, 32'd5, 32'd6, 0, n);
      wait_cycle(n + 10);
      cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      @(negedge clk);
      check("cancel_busy", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      check("cancel_hi", hi, 32'h11);
      check("cancel_lo", lo, 32'h22);

      // cancel coincident with start from idle
      @(posedge clk); #1 cancel = 1'b1;
      issue(MD_DIVU, 32'd9, 32'd3, 0, n);
      cancel = 1'b0;
      @(negedge clk);
      check("start_cancel_busy", 32'(busy), 32'd0);

      // reset mid-operation
      issue(MD_MULT, 32'd5, 32'd6, 0, n);
      wait_cycle(n + 10);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_hi", hi, 32'd0);
      check("midreset_lo", lo, 32'd0);

      issue(MD_MULT, 32'd5, 32'd6, 1, n);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick(), 1, n);
         wait_idle();
      end

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
